// File: rtl/draw_arbiter.sv
// Arbitrates N drawing engines onto one registered VGA plot port.
// One grant at a time, fixed-priority or round-robin, with a per-grant watchdog.
module draw_arbiter #(
  parameter int unsigned N_CH    = 6,
  parameter int unsigned X_W     = 8,
  parameter int unsigned Y_W     = 7,
  parameter int unsigned C_W     = 3,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned TO_W    = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*X_W-1:0]   ch_x,
  input  logic [N_CH*Y_W-1:0]   ch_y,
  input  logic [N_CH*C_W-1:0]   ch_color,
  input  logic [N_CH-1:0]       ch_plot,
  input  logic [N_CH-1:0]       ch_done,
  output logic [N_CH-1:0]       grant,
  output logic                  busy,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [C_W-1:0]        color_out,
  output logic                  plot,
  output logic [N_CH-1:0]       done_pulse,
  output logic                  timeout_err
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [TO_W-1:0] WD_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_REL} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [C_W-1:0]    c_q, c_d;
  logic              plot_q, plot_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic              terr_q, terr_d;

  logic [X_W-1:0]    x_arr [N_CH];
  logic [Y_W-1:0]    y_arr [N_CH];
  logic [C_W-1:0]    c_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign x_arr[i] = ch_x[i*X_W +: X_W];
    assign y_arr[i] = ch_y[i*Y_W +: Y_W];
    assign c_arr[i] = ch_color[i*C_W +: C_W];
  end

  // Winner search starting at the RR pointer (or 0), wrapping by explicit compare
  logic              found;
  logic [IDX_W-1:0]  sel;
  int unsigned       idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < N_CH; off++) begin
      idx = ((RR_MODE != 0) ? int'(ptr_q) : 0) + off;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  logic expire;
  assign expire = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    done_d  = '0;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = sel;
          grant_d = N_CH'(1) << sel;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        plot_d = ch_plot[win_q];
        if (ch_plot[win_q]) begin
          x_d = x_arr[win_q];
          y_d = y_arr[win_q];
          c_d = c_arr[win_q];
        end
        // Done takes precedence over a simultaneous watchdog expiry
        if (ch_done[win_q]) begin
          grant_d = '0;
          busy_d  = 1'b0;
          plot_d  = 1'b0;
          done_d  = grant_q;
          state_d = S_REL;
        end else if (expire) begin
          grant_d = '0;
          busy_d  = 1'b0;
          plot_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = S_REL;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_REL: begin
        if (RR_MODE != 0) begin
          ptr_d = (win_q == IDX_W'(N_CH - 1)) ? '0 : win_q + IDX_W'(1);
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      win_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      done_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign x_out       = x_q;
  assign y_out       = y_q;
  assign color_out   = c_q;
  assign plot        = plot_q;
  assign done_pulse  = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: a fixed-priority instance (TIMEOUT=16)
// and a round-robin instance share stimulus.
module tb_draw_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  req;
  logic [47:0] ch_x;
  logic [41:0] ch_y;
  logic [17:0] ch_color;
  logic [5:0]  ch_plot;
  logic [5:0]  ch_done;

  logic [5:0] f_grant, f_done;
  logic       f_busy, f_plot, f_terr;
  logic [7:0] f_x;
  logic [6:0] f_y;
  logic [2:0] f_c;

  logic [5:0] r_grant, r_done;
  logic       r_busy, r_plot, r_terr;
  logic [7:0] r_x;
  logic [6:0] r_y;
  logic [2:0] r_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  draw_arbiter #(.N_CH(6), .RR_MODE(0), .TIMEOUT(16), .TO_W(15)) u_fix (
    .clk(clk), .resetn(resetn), .req(req), .ch_x(ch_x), .ch_y(ch_y),
    .ch_color(ch_color), .ch_plot(ch_plot), .ch_done(ch_done),
    .grant(f_grant), .busy(f_busy), .x_out(f_x), .y_out(f_y),
    .color_out(f_c), .plot(f_plot), .done_pulse(f_done), .timeout_err(f_terr)
  );

  draw_arbiter #(.N_CH(6), .RR_MODE(1)) u_rr (
    .clk(clk), .resetn(resetn), .req(req), .ch_x(ch_x), .ch_y(ch_y),
    .ch_color(ch_color), .ch_plot(ch_plot), .ch_done(ch_done),
    .grant(r_grant), .busy(r_busy), .x_out(r_x), .y_out(r_y),
    .color_out(r_c), .plot(r_plot), .done_pulse(r_done), .timeout_err(r_terr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp_g;
    int gap;

    resetn = 1'b0; req = '0; ch_x = '0; ch_y = '0; ch_color = '0;
    ch_plot = '0; ch_done = '0;
    step(); step();
    chk("rst_grant", 32'(f_grant), 32'(0));
    chk("rst_busy",  32'(f_busy),  32'(0));
    chk("rst_plot",  32'(f_plot),  32'(0));
    chk("rst_x",     32'(f_x),     32'(0));
    chk("rst_done",  32'(f_done),  32'(0));
    chk("rst_terr",  32'(f_terr),  32'(0));
    resetn = 1'b1;
    step();

    // Fixed priority, pixel path, done and re-grant of the next channel
    req = 6'b000101;
    step();
    chk("fp_grant0", 32'(f_grant), 32'(6'b000001));
    chk("fp_busy",   32'(f_busy),  32'(1));
    ch_plot = 6'b000001; ch_x[7:0] = 8'd10; ch_y[6:0] = 7'd20; ch_color[2:0] = 3'd3;
    step();
    chk("pix_x",    32'(f_x),    32'(10));
    chk("pix_y",    32'(f_y),    32'(20));
    chk("pix_c",    32'(f_c),    32'(3));
    chk("pix_plot", 32'(f_plot), 32'(1));
    ch_plot = '0;
    step();
    chk("pix_plot_off", 32'(f_plot), 32'(0));
    chk("pix_x_hold",   32'(f_x),    32'(10));
    ch_done = 6'b000001; req = 6'b000100;
    step();
    chk("done_grant", 32'(f_grant), 32'(0));
    chk("done_pulse", 32'(f_done),  32'(6'b000001));
    chk("done_busy",  32'(f_busy),  32'(0));
    ch_done = '0;
    step();
    chk("idle_grant", 32'(f_grant), 32'(0));
    chk("idle_pulse", 32'(f_done),  32'(0));
    step();
    chk("fp_grant2", 32'(f_grant), 32'(6'b000100));

    // Watchdog: channel 2 never finishes
    repeat (15) step();
    chk("wd_held", 32'(f_grant), 32'(6'b000100));
    step();
    chk("wd_drop",  32'(f_grant), 32'(0));
    chk("wd_terr",  32'(f_terr),  32'(1));
    chk("wd_nodone", 32'(f_done), 32'(0));
    req = 6'b000010;
    step();
    chk("wd_idle", 32'(f_grant), 32'(0));
    step();
    chk("wd_next_grant", 32'(f_grant), 32'(6'b000010));
    chk("wd_sticky",     32'(f_terr),  32'(1));
    ch_done = 6'b000010; req = '0;
    step();
    chk("wd_next_done", 32'(f_done), 32'(6'b000010));
    ch_done = '0;
    step();

    // Grant is locked; foreign done and req changes are ignored
    req = 6'b000001;
    step();
    chk("lock_grant", 32'(f_grant), 32'(6'b000001));
    req = 6'b000010; ch_done = 6'b001000;
    step();
    chk("lock_hold",   32'(f_grant), 32'(6'b000001));
    chk("lock_nodone", 32'(f_done),  32'(0));
    ch_done = '0;
    step();
    chk("lock_hold2", 32'(f_grant), 32'(6'b000001));
    ch_done = 6'b000001;
    step();
    chk("lock_end",  32'(f_grant), 32'(0));
    chk("lock_done", 32'(f_done),  32'(6'b000001));
    ch_done = '0;
    step(); step();
    chk("lock_next", 32'(f_grant), 32'(6'b000010));
    ch_done = 6'b000010; req = '0;
    step();
    chk("lock_next_done", 32'(f_done), 32'(6'b000010));
    ch_done = '0;
    step();

    // Async reset mid-draw while plotting
    req = 6'b000001;
    step();
    chk("ar_grant", 32'(f_grant), 32'(6'b000001));
    ch_plot = 6'b000001; ch_x[7:0] = 8'd77;
    step();
    chk("ar_plot", 32'(f_plot), 32'(1));
    chk("ar_x",    32'(f_x),    32'(77));
    ch_plot = '0;
    resetn = 1'b0;
    #1;
    chk("ar_rst_grant", 32'(f_grant), 32'(0));
    chk("ar_rst_plot",  32'(f_plot),  32'(0));
    chk("ar_rst_busy",  32'(f_busy),  32'(0));
    chk("ar_rst_x",     32'(f_x),     32'(0));
    chk("ar_rst_terr",  32'(f_terr),  32'(0));
    step();
    resetn = 1'b1;
    step();
    chk("ar_regrant", 32'(f_grant), 32'(6'b000001));

    // Done coinciding with watchdog expiry
    repeat (15) step();
    chk("tie_held", 32'(f_grant), 32'(6'b000001));
    ch_done = 6'b000001; req = '0;
    step();
    chk("tie_done",  32'(f_done),  32'(6'b000001));
    chk("tie_terr",  32'(f_terr),  32'(0));
    chk("tie_grant", 32'(f_grant), 32'(0));
    ch_done = '0;
    step();

    // Round-robin rotation with 5-cycle draws
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    req = 6'b111111;
    step();
    gap = 0;
    for (int k = 0; k < 7; k++) begin
      exp_g = 6'(1) << (k % 6);
      if (k > 0) chk("rr_gap", 32'(gap), 32'(2));
      chk("rr_grant", 32'(r_grant), 32'(exp_g));
      repeat (4) step();
      ch_done = exp_g;
      step();
      chk("rr_done", 32'(r_done), 32'(exp_g));
      ch_done = '0;
      if (k < 6) begin
        gap = 1;
        for (int w = 0; w < 8; w++) begin
          step();
          if (r_grant != 0) break;
          gap++;
        end
        chk("rr_wait", 32'(r_grant != 0), 32'(1));
      end
    end
    req = '0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Parametrised successor to the game-state plot multiplexer: arbitrates N drawing engines (grid, number, clear, ...) onto one VGA plotter port.
- Replaces the combinational priority mux with a granted, handshaked, registered path.
- Only one engine runs at a time. Selection is fixed-priority or round-robin, with a per-grant watchdog timeout.
- Sits between the drawer modules and the VGA adapter (x, y, colour, plot).

Parameters:
- N_CH, 6, number of drawer channels (2..16)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 3, colour width
- RR_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
- TIMEOUT, 20000, max cycles a grant may be held without done; 0 disables the watchdog
- TO_W, 15, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req  in  N_CH  per-channel draw request (level)
- ch_x  in  N_CH*X_W  packed x; channel i at [i*X_W +: X_W]
- ch_y  in  N_CH*Y_W  packed y
- ch_color  in  N_CH*C_W  packed colour
- ch_plot  in  N_CH  per-channel pixel-valid
- ch_done  in  N_CH  per-channel completion pulse/level
- grant  out  N_CH  one-hot enable to drawers; all-zero when idle
- busy  out  1  high while any grant is active
- x_out  out  X_W  registered plot x
- y_out  out  Y_W  registered plot y
- color_out  out  C_W  registered plot colour
- plot  out  1  registered pixel write strobe
- done_pulse  out  N_CH  one-cycle pulse on the channel whose grant ended normally
- timeout_err  out  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; grant=0, busy=0, plot=0.
  - x_out/y_out/color_out = 0; done_pulse=0, timeout_err=0.
  - RR pointer = 0; watchdog = 0.
- States: IDLE -> DRAW -> RELEASE -> IDLE.
- IDLE:
  - If req is nonzero, select a winner.
  - Fixed mode: lowest set index wins.
  - RR mode: first set index at or after the pointer, wrapping modulo N_CH.
  - Next cycle: grant = onehot(winner), busy=1, watchdog cleared, go DRAW.
  - If req is zero, stay in IDLE.
- DRAW:
  - grant is held constant; changes to req, including deassertion of the winner's req, are ignored.
  - Each cycle: plot <= ch_plot[win]; x_out/y_out/color_out <= winner slice when ch_plot[win]=1, else hold their previous values.
  - Latency: drawer pixel to plot output = 1 cycle.
  - ch_done[win]=1: next cycle grant=0, plot=0, done_pulse[win]=1, go RELEASE.
  - ch_done on non-winning channels is ignored.
  - Watchdog increments every DRAW cycle. When TIMEOUT≠0 and watchdog reaches TIMEOUT-1 without done: next cycle grant=0, plot=0, timeout_err=1, no done_pulse, go RELEASE.
  - Done and expiry in the same cycle: done wins (done_pulse asserted, timeout_err unchanged).
- RELEASE:
  - Exactly one cycle with grant=0, busy=0. This gives the drawer time to reset its internal counters.
  - RR mode: pointer <= (win+1) mod N_CH, updated after both normal and timeout release.
  - Go IDLE. A request still pending is therefore re-granted no sooner than 2 cycles after release.
- Minimum grant-to-grant gap: 2 cycles (RELEASE, then IDLE arbitration).
- done_pulse is never asserted in a cycle where grant is nonzero.
- plot is never 1 outside DRAW+1.
- N_CH not a power of two: the RR wrap uses an explicit compare, not truncation.

Test Plan:
- Reset then req=6'b000101, fixed mode -> grant=000001 on the cycle after req. Drive ch_plot[0] with x=10, y=20, colour=3 -> next cycle x_out=10, y_out=20, color_out=3, plot=1. ch_done[0] -> grant=0, done_pulse=000001. Two cycles later grant=000100.
- RR_MODE=1, req held at 6'b111111, each drawer completes after 5 cycles -> grants cycle 0,1,2,3,4,5,0, each separated by exactly 2 idle cycles.
- TIMEOUT=16, channel 2 granted, never asserts done -> grant drops after exactly 16 DRAW cycles, timeout_err=1 and stays 1. A following req on channel 1 is still served.
- Channel 0 granted; mid-draw req[0] deasserted and req[1] raised; ch_done[3] pulsed -> grant stays 000001 until ch_done[0]; no done_pulse on channel 3.
- resetn pulsed low mid-DRAW with plot=1 -> immediately grant=0, plot=0, busy=0, x_out=0, timeout_err=0. With req held, first grant comes 1 cycle after resetn rises.
- ch_done[win] and watchdog expiry in the same cycle -> done_pulse asserted, timeout_err remains 0.
